// File: rtl/booth_mul.sv
// booth_mul: sequential signed WIDTH x WIDTH multiplier, radix-4 Booth recoding, bgn/fin handshake
//   clk    : clock, rising edge
//   rst_b  : asynchronous active-low reset
//   bgn    : start request, sampled only in IDLE
//   ibusA  : multiplicand (signed), ibusB : multiplier (signed)
//   obusA  : product high word while fin, else z
//   obusB  : product low word while fin, else z
//   fin    : one-cycle done strobe
//   BOOTH_MUL_SKIP_ZERO_EN : when defined, zero Booth digits shift in the ADD cycle
module booth_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             bgn,
  input  logic [WIDTH-1:0] ibusA,
  input  logic [WIDTH-1:0] ibusB,
  output logic [WIDTH-1:0] obusA,
  output logic [WIDTH-1:0] obusB,
  output logic             fin
);
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2) + 1;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, OUT} state_t;
  state_t state;
  logic [AW-1:0] a, m, mop, addend, sum, sh_a;
  logic [WIDTH-1:0] q, sh_q;
  logic q_m1;
  logic [CW-1:0] cnt;
  logic [2:0] dig;
  logic zero, neg, dbl, last;
  assign dig = {q[1:0], q_m1};
  assign zero = dig == 3'b000 || dig == 3'b111;
  assign neg = dig[2] & ~zero;
  assign dbl = dig == 3'b011 || dig == 3'b100;
  assign mop = dbl ? {m[AW-2:0], 1'b0} : m;
  // negative digits use the inverted operand plus carry-in
  assign addend = zero ? '0 : neg ? ~mop : mop;
  assign sum = a + addend + {{(AW-1){1'b0}}, neg};
  assign sh_a = {{2{a[AW-1]}}, a[AW-1:2]};
  assign sh_q = {a[1:0], q[WIDTH-1:2]};
  assign last = cnt == CW'(WIDTH / 2 - 1);
  assign fin = state == OUT;
  assign obusA = fin ? a[WIDTH-1:0] : 'z;
  assign obusB = fin ? q : 'z;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state <= IDLE;
      a <= '0;
      m <= '0;
      q <= '0;
      q_m1 <= 1'b0;
      cnt <= '0;
    end else
      case (state)
        IDLE:
          if (bgn) begin
            m <= {{2{ibusA[WIDTH-1]}}, ibusA};
            q <= ibusB;
            a <= '0;
            q_m1 <= 1'b0;
            cnt <= '0;
            state <= ADD;
          end
        ADD:
`ifdef BOOTH_MUL_SKIP_ZERO_EN
          if (zero) begin
            a <= sh_a;
            q <= sh_q;
            q_m1 <= q[1];
            cnt <= cnt + CW'(1);
            state <= last ? OUT : ADD;
          end else
`endif
          begin
            a <= sum;
            state <= SHIFT;
          end
        SHIFT: begin
          a <= sh_a;
          q <= sh_q;
          q_m1 <= q[1];
          cnt <= cnt + CW'(1);
          state <= last ? OUT : ADD;
        end
        OUT: state <= IDLE;
      endcase
endmodule
